// File: rtl/traffic_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the intersection phase controller:
//   - 2-bit lamp codes (RED / GREEN / YELLOW; code 3 is never driven)
//   - phase FSM state enum (S_WALK is only reachable with TRAFFIC_PED_EN)
//   - clog2 helper used for index widths
// ----------------------------------------------------------------------------
package traffic_pkg;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] GREEN  = 2'd1;
    localparam logic [1:0] YELLOW = 2'd2;

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2,
        S_WALK   = 2'd3
    } state_t;

    // Ceiling log2, minimum 1 so an index signal never collapses to zero width.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << r) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// ----------------------------------------------------------------------------
// rr_next_sel
// Combinational round-robin picker. Searches cur_idx+1, cur_idx+2, ... modulo
// N and returns the first requesting approach. cur_idx itself is never chosen.
//   req       in  N      request vector
//   cur_idx   in  IDX_W  approach currently holding right-of-way
//   win_idx   out IDX_W  winning approach (cur_idx when nothing requests)
//   win_valid out 1      some approach other than cur_idx is requesting
// ----------------------------------------------------------------------------
module rr_next_sel
    import traffic_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] cur_idx,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_valid
);

    logic [IDX_W-1:0] cand_idx [N];
    logic [N-1:0]     hit;

    // Candidate at rotation offset gi; offset 0 is the current holder and is
    // masked off so it can never win.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        if (gi == 0) begin : g_self
            assign cand_idx[gi] = cur_idx;
            assign hit[gi]      = 1'b0;
        end else begin : g_other
            logic [IDX_W:0] sum;
            assign sum          = {1'b0, cur_idx} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                         : IDX_W'(sum);
            assign hit[gi]      = req[cand_idx[gi]];
        end
    end

    // Walk from the farthest offset down so the nearest hit is written last.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = cur_idx;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// ----------------------------------------------------------------------------
// traffic_phase_ctrl
// N-approach intersection phase controller. One approach is green at a time;
// the next approach is chosen round-robin among waiting cars. Minimum / maximum
// green, fixed yellow and all-red clearance are timed internally.
//   clk          in  1            clock, rising edge
//   rst          in  1            asynchronous active-high reset
//   car_present  in  N_APPROACH   per-approach car sensor (level)
//   light        out 2*N_APPROACH lamp code, approach i at [2i+1:2i]
//   active_idx   out IDX_W        approach holding / finishing right-of-way
//   phase_change out 1            pulse on each entry to GREEN
// Optional build macro TRAFFIC_PED_EN adds a pedestrian walk phase:
//   parameter WALK_T, input ped_req (pulse), output walk.
// All outputs are registered from next-state values.
// ----------------------------------------------------------------------------
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int N_APPROACH = 4,
    parameter int CNT_W      = 8,
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 10,
    parameter int YELLOW_T   = 3,
    parameter int ALLRED_T   = 2
`ifdef TRAFFIC_PED_EN
    ,
    parameter int WALK_T     = 6
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_APPROACH-1:0]         car_present,
`ifdef TRAFFIC_PED_EN
    input  logic                          ped_req,
    output logic                          walk,
`endif
    output logic [2*N_APPROACH-1:0]       light,
    output logic [clog2(N_APPROACH)-1:0]  active_idx,
    output logic                          phase_change
);

    localparam int IDX_W = clog2(N_APPROACH);

    localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LIM   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LIM  = CNT_W'(ALLRED_T - 1);
`ifdef TRAFFIC_PED_EN
    localparam logic [CNT_W-1:0] WALK_LIM = CNT_W'(WALK_T - 1);
`endif

    localparam logic [2*N_APPROACH-1:0] RESET_LIGHT = (2*N_APPROACH)'(GREEN);

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        timer_reg, timer_next;
    logic [IDX_W-1:0]        active_reg, active_next;
    logic [IDX_W-1:0]        next_idx_reg, next_idx_next;
    logic [2*N_APPROACH-1:0] light_reg, light_next;
    logic                    pc_reg, pc_next;
    logic [1:0]              lamp_active;

    logic [IDX_W-1:0]        rr_idx;
    logic                    other_req;

`ifdef TRAFFIC_PED_EN
    logic ped_pend_reg, ped_pend_next;
    logic ped_again_reg, ped_again_next;
    logic walk_reg, walk_next;
`endif

    // Round-robin winner excluding the active approach; its valid flag is
    // exactly "some other approach is requesting".
    rr_next_sel #(
        .N (N_APPROACH)
    ) u_rr (
        .req       (car_present),
        .cur_idx   (active_reg),
        .win_idx   (rr_idx),
        .win_valid (other_req)
    );

    always_comb begin
        state_next    = state_reg;
        active_next   = active_reg;
        next_idx_next = next_idx_reg;
        unique case (state_reg)
            S_GREEN: begin
                // An uncontested green holds forever; contested green ends at
                // MAX only while the active approach is still occupied.
                if ((timer_reg >= MIN_LIM) && other_req &&
                    (!car_present[active_reg] || (timer_reg >= MAX_LIM))) begin
                    state_next    = S_YELLOW;
                    next_idx_next = rr_idx;
                end
            end
            S_YELLOW: begin
                if (timer_reg == Y_LIM) begin
                    state_next = S_ALLRED;
                end
            end
            S_ALLRED: begin
                if (timer_reg == AR_LIM) begin
`ifdef TRAFFIC_PED_EN
                    if (ped_pend_reg) begin
                        state_next = S_WALK;
                    end else begin
                        state_next  = S_GREEN;
                        active_next = next_idx_reg;
                    end
`else
                    state_next  = S_GREEN;
                    active_next = next_idx_reg;
`endif
                end
            end
`ifdef TRAFFIC_PED_EN
            S_WALK: begin
                if (timer_reg == WALK_LIM) begin
                    state_next  = S_GREEN;
                    active_next = next_idx_reg;
                end
            end
`endif
            default: begin
                state_next = S_GREEN;
            end
        endcase
    end

    // Timer restarts on every state entry and saturates otherwise.
    always_comb begin
        if (state_next != state_reg) begin
            timer_next = '0;
        end else if (timer_reg == {CNT_W{1'b1}}) begin
            timer_next = timer_reg;
        end else begin
            timer_next = timer_reg + 1'b1;
        end
    end

`ifdef TRAFFIC_PED_EN
    // A request seen during the walk itself is kept for the following cycle
    // of service instead of being swallowed by the end-of-walk clear.
    always_comb begin
        ped_pend_next  = ped_pend_reg;
        ped_again_next = ped_again_reg;
        if (state_reg == S_WALK) begin
            if (ped_req) begin
                ped_again_next = 1'b1;
            end
            if (state_next != S_WALK) begin
                ped_pend_next  = ped_again_reg | ped_req;
                ped_again_next = 1'b0;
            end
        end else if (ped_req) begin
            ped_pend_next = 1'b1;
        end
    end

    assign walk_next = (state_next == S_WALK);
`endif

    // Only the active approach can be non-RED, which keeps at most one lamp lit.
    always_comb begin
        lamp_active = RED;
        if (state_next == S_GREEN) begin
            lamp_active = GREEN;
        end else if (state_next == S_YELLOW) begin
            lamp_active = YELLOW;
        end
    end

    for (genvar gi = 0; gi < N_APPROACH; gi++) begin : g_lamp
        assign light_next[2*gi +: 2] = (active_next == IDX_W'(gi)) ? lamp_active : RED;
    end

    assign pc_next = (state_next == S_GREEN) && (state_reg != S_GREEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_GREEN;
            timer_reg    <= '0;
            active_reg   <= '0;
            next_idx_reg <= '0;
            light_reg    <= RESET_LIGHT;
            pc_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            active_reg   <= active_next;
            next_idx_reg <= next_idx_next;
            light_reg    <= light_next;
            pc_reg       <= pc_next;
        end
    end

`ifdef TRAFFIC_PED_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pend_reg  <= 1'b0;
            ped_again_reg <= 1'b0;
            walk_reg      <= 1'b0;
        end else begin
            ped_pend_reg  <= ped_pend_next;
            ped_again_reg <= ped_again_next;
            walk_reg      <= walk_next;
        end
    end

    assign walk = walk_reg;
`endif

    assign light        = light_reg;
    assign active_idx   = active_reg;
    assign phase_change = pc_reg;

endmodule
